// File: rtl/alu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the shared-ALU controller:
//   - ALU control codes understood by the shared ALU
//   - FSM state encoding for alu_share_ctrl
//   - legal multiply-latency range and the counter width it implies
//   - helper that classifies an op code as single-cycle or multiply
// ----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam logic [2:0] ALUCTRL_AND = 3'b000;
  localparam logic [2:0] ALUCTRL_OR  = 3'b001;
  localparam logic [2:0] ALUCTRL_ADD = 3'b010;
  localparam logic [2:0] ALUCTRL_SUB = 3'b110;
  localparam logic [2:0] ALUCTRL_MUL = 3'b100;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 16;
  // The wait counter is loaded with MUL_LAT-1, so MUL_LAT_MAX-1 must fit.
  localparam int MUL_CNT_W   = $clog2(MUL_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULW = 2'd2,
    RESP = 2'd3
  } state_e;

  // Every code outside the four simple ops is treated as a multiply.
  function automatic logic is_single_cycle(input logic [2:0] ctrl);
    return (ctrl == ALUCTRL_AND) || (ctrl == ALUCTRL_OR) ||
           (ctrl == ALUCTRL_ADD) || (ctrl == ALUCTRL_SUB);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_alu
// Shared combinational ALU. All results are 32 bits modulo 2^32.
// Ports:
//   data1_i    in  32  operand A
//   data2_i    in  32  operand B
//   ALUCtrl_i  in  3   op code (000 and, 001 or, 010 add, 110 sub, else mul)
//   result_o   out 32  result (low 32 bits of the product for multiply)
//   zero_o     out 1   result == 0
// ----------------------------------------------------------------------------
module alu_share_ctrl_alu
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [2:0]  ALUCtrl_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = data1_i * data2_i;
    case (ALUCtrl_i)
      ALUCTRL_AND: result_o = data1_i & data2_i;
      ALUCTRL_OR:  result_o = data1_i | data2_i;
      ALUCTRL_ADD: result_o = data1_i + data2_i;
      ALUCTRL_SUB: result_o = data1_i - data2_i;
      default:     result_o = data1_i * data2_i;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/alu_share_ctrl_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. The last_grant register only moves when the
// owner reports an accepted transfer, so a requester that drops valid
// before being accepted does not lose or gain priority.
// Ports:
//   clk_i        in  1  clock, rising edge
//   rst_i        in  1  asynchronous reset, active-low (last_grant -> 1)
//   req0_i       in  1  requester 0 valid
//   req1_i       in  1  requester 1 valid
//   accept_i     in  1  a grant was taken this cycle
//   accept_id_i  in  1  id of the requester that was accepted
//   grant_id_o   out 1  requester currently granted
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic accept_i,
  input  logic accept_id_i,
  output logic grant_id_o
);

  logic last_grant_q;
  logic last_grant_d;

  // A lone requester always wins; on a tie (or when idle) the requester
  // that was not served last is favoured.
  always_comb begin
    grant_id_o = ~last_grant_q;
    if (req0_i && !req1_i) begin
      grant_id_o = 1'b0;
    end else if (req1_i && !req0_i) begin
      grant_id_o = 1'b1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) begin
      last_grant_d = accept_id_i;
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
// Shares one ALU between requester 0 (pipeline EX stage) and requester 1
// (auxiliary address/loop unit). Arbitrates round-robin, latches the
// operands of the accepted request, runs simple ops in one cycle and
// multiplies in MUL_LAT cycles, then holds a registered response until the
// consumer takes it.
// Parameters:
//   MUL_LAT  cycles spent on a multiply, legal range 1..16
// Ports:
//   clk_i           in  1   clock, rising edge
//   rst_i           in  1   asynchronous reset, active-low
//   reqN_valid_i    in  1   requester N has an operation
//   reqN_ready_o    out 1   requester N accepted when valid & ready
//   reqN_data1_i    in  32  operand A
//   reqN_data2_i    in  32  operand B
//   reqN_ALUCtrl_i  in  3   op code
//   rsp_valid_o     out 1   result valid
//   rsp_ready_i     in  1   consumer takes result
//   rsp_data_o      out 32  result
//   rsp_Zero_o      out 1   result == 0
//   rsp_id_o        out 1   requester that issued the result
//   busy_o          out 1   controller not idle
// ----------------------------------------------------------------------------
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ALUCtrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ALUCtrl_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_Zero_o,
  output logic        rsp_id_o,
  output logic        busy_o
);

  localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT = MUL_CNT_W'(MUL_LAT - 1);
  localparam logic                 MUL_IS_SHORT = (MUL_LAT == 1);

  state_e               state_q, state_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic                 id_q, id_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_id_q, rsp_id_d;

  logic                 grant_id;
  logic                 in_idle;
  logic                 accept;
  logic [31:0]          sel_data1;
  logic [31:0]          sel_data2;
  logic [2:0]           sel_ctrl;
  logic [31:0]          alu_result;
  logic                 alu_zero;

  rr_arb2 u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_valid_i),
    .req1_i      (req1_valid_i),
    .accept_i    (accept),
    .accept_id_i (grant_id),
    .grant_id_o  (grant_id)
  );

  // The ALU only ever sees the latched operands, which stay constant for
  // the whole multiply wait.
  alu_share_ctrl_alu u_alu (
    .data1_i   (a_q),
    .data2_i   (b_q),
    .ALUCtrl_i (ctrl_q),
    .result_o  (alu_result),
    .zero_o    (alu_zero)
  );

  // Ready is gated by rst_i so nothing can be accepted while in reset.
  assign in_idle      = (state_q == IDLE);
  assign req0_ready_o = in_idle && !grant_id && rst_i;
  assign req1_ready_o = in_idle &&  grant_id && rst_i;
  assign accept       = (req0_valid_i && req0_ready_o) ||
                        (req1_valid_i && req1_ready_o);

  assign sel_data1 = grant_id ? req1_data1_i   : req0_data1_i;
  assign sel_data2 = grant_id ? req1_data2_i   : req0_data2_i;
  assign sel_ctrl  = grant_id ? req1_ALUCtrl_i : req0_ALUCtrl_i;

  // Next-state and datapath update. Operands move only on accept; the
  // response registers move only when a result is captured or consumed.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d    = sel_data1;
          b_d    = sel_data2;
          ctrl_d = sel_ctrl;
          id_d   = grant_id;
          if (is_single_cycle(sel_ctrl) || MUL_IS_SHORT) begin
            state_d = EXEC;
          end else begin
            state_d = MULW;
            cnt_d   = MUL_CNT_INIT;
          end
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_result;
        rsp_zero_d  = alu_zero;
        rsp_id_d    = id_q;
        state_d     = RESP;
      end
      MULW: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_result;
          rsp_zero_d  = alu_zero;
          rsp_id_d    = id_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset mid-operation simply discards it: state returns to IDLE and
  // the response registers clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_Zero_o  = rsp_zero_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Self-checking bench for alu_share_ctrl with MUL_LAT = 4. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam int MUL_LAT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req0_valid_i = 1'b0;
  logic        req0_ready_o;
  logic [31:0] req0_data1_i = '0;
  logic [31:0] req0_data2_i = '0;
  logic [2:0]  req0_ALUCtrl_i = '0;
  logic        req1_valid_i = 1'b0;
  logic        req1_ready_o;
  logic [31:0] req1_data1_i = '0;
  logic [31:0] req1_data2_i = '0;
  logic [2:0]  req1_ALUCtrl_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_data_o;
  logic        rsp_Zero_o;
  logic        rsp_id_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  alu_share_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req0_valid_i   (req0_valid_i),
    .req0_ready_o   (req0_ready_o),
    .req0_data1_i   (req0_data1_i),
    .req0_data2_i   (req0_data2_i),
    .req0_ALUCtrl_i (req0_ALUCtrl_i),
    .req1_valid_i   (req1_valid_i),
    .req1_ready_o   (req1_ready_o),
    .req1_data1_i   (req1_data1_i),
    .req1_data2_i   (req1_data2_i),
    .req1_ALUCtrl_i (req1_ALUCtrl_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_Zero_o     (rsp_Zero_o),
    .rsp_id_o       (rsp_id_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        id;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] expData;
    logic        expZero;
    int          expLat;
  } vec_t;

  exp_t sbQueue[$];
  logic acceptIds[$];
  exp_t sbHead;
  vec_t vecs[9];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic logic [31:0] modelAlu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] ctrl);
    case (ctrl)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return a * b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: expected result pushed when a request is accepted, popped
  // when the consumer takes a response.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (req0_valid_i && req0_ready_o) begin
        sbQueue.push_back('{modelAlu(req0_data1_i, req0_data2_i, req0_ALUCtrl_i),
                            modelAlu(req0_data1_i, req0_data2_i, req0_ALUCtrl_i) == 32'd0,
                            1'b0});
        acceptIds.push_back(1'b0);
      end
      if (req1_valid_i && req1_ready_o) begin
        sbQueue.push_back('{modelAlu(req1_data1_i, req1_data2_i, req1_ALUCtrl_i),
                            modelAlu(req1_data1_i, req1_data2_i, req1_ALUCtrl_i) == 32'd0,
                            1'b1});
        acceptIds.push_back(1'b1);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          sbHead = sbQueue.pop_front();
          checkOutput("sb_data", rsp_data_o, sbHead.data);
          checkOutput("sb_zero", 32'(rsp_Zero_o), 32'(sbHead.zero));
          checkOutput("sb_id", 32'(rsp_id_o), 32'(sbHead.id));
        end
      end
    end
  end

  // One isolated request through the whole flow, with latency measured in
  // cycles from the accepting edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    bit seen;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    if (v.id == 1'b0) begin
      req0_valid_i = 1'b1; req0_data1_i = v.a; req0_data2_i = v.b; req0_ALUCtrl_i = v.ctrl;
    end else begin
      req1_valid_i = 1'b1; req1_data1_i = v.a; req1_data2_i = v.b; req1_ALUCtrl_i = v.ctrl;
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if ((v.id == 1'b0 && req0_ready_o) || (v.id == 1'b1 && req1_ready_o)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_accept"}, 32'(seen), 32'd1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        lat = i;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, "_data"}, rsp_data_o, v.expData);
    checkOutput({tag, "_zero"}, 32'(rsp_Zero_o), 32'(v.expZero));
    checkOutput({tag, "_id"}, 32'(rsp_id_o), 32'(v.id));
  endtask

  task automatic waitDrain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (!busy_o && !rsp_valid_o && sbQueue.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int highCnt;
    bit seen;

    vecs[0] = '{1'b0, 32'd5,          32'd7,          3'b010, 32'd12,         1'b0, 2};
    vecs[1] = '{1'b1, 32'd9,          32'd9,          3'b110, 32'd0,          1'b1, 2};
    vecs[2] = '{1'b1, 32'd0,          32'd1,          3'b110, 32'hFFFFFFFF,   1'b0, 2};
    vecs[3] = '{1'b0, 32'd3,          32'hFFFFFFFE,   3'b100, 32'hFFFFFFFA,   1'b0, 1 + MUL_LAT};
    vecs[4] = '{1'b0, 32'd3,          32'hFFFFFFFE,   3'b111, 32'hFFFFFFFA,   1'b0, 1 + MUL_LAT};
    vecs[5] = '{1'b1, 32'h000000F0,   32'h0000000F,   3'b001, 32'h000000FF,   1'b0, 2};
    vecs[6] = '{1'b0, 32'hF0F0F0F0,   32'h0F0F0F0F,   3'b000, 32'd0,          1'b1, 2};
    vecs[7] = '{1'b1, 32'h00010000,   32'h00010000,   3'b011, 32'd0,          1'b1, 1 + MUL_LAT};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,          3'b010, 32'd0,          1'b1, 2};

    // Reset state, with a request held high to show ready stays low.
    req0_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_rsp_data", rsp_data_o, 32'd0);
    checkOutput("reset_rsp_zero", 32'(rsp_Zero_o), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id_o), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_ready0", 32'(req0_ready_o), 32'd0);
    checkOutput("reset_ready1", 32'(req1_ready_o), 32'd0);
    req0_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    $display("[TB] table-driven vectors");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k], $sformatf("vec%0d", k));
    end
    waitDrain("vectors");

    $display("[TB] reset during multiply wait");
    @(posedge clk_i); #1;
    req0_valid_i = 1'b1; req0_data1_i = 32'd3; req0_data2_i = 32'd5; req0_ALUCtrl_i = 3'b100;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req0_ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midop_accept", 32'(seen), 32'd1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("midop_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    checkOutput("midop_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("midop_busy", 32'(busy_o), 32'd0);
    checkOutput("midop_ready0", 32'(req0_ready_o), 32'd0);
    sbQueue.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    highCnt = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (rsp_valid_o || busy_o) highCnt++;
    end
    checkOutput("midop_no_rsp_after_release", 32'(highCnt), 32'd0);

    $display("[TB] contention");
    @(posedge clk_i); #1;
    acceptIds.delete();
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_data1_i = 32'd1;        req0_data2_i = 32'd1;        req0_ALUCtrl_i = 3'b010;
    req1_valid_i = 1'b1; req1_data1_i = 32'h000000F0; req1_data2_i = 32'h0000000F; req1_ALUCtrl_i = 3'b001;
    @(negedge clk_i);
    checkOutput("first_grant_ready0", 32'(req0_ready_o), 32'd1);
    checkOutput("first_grant_ready1", 32'(req1_ready_o), 32'd0);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_i); #1;
      if (acceptIds.size() >= 4) break;
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    checkOutput("contention_accepts", 32'(acceptIds.size()), 32'd4);
    if (acceptIds.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("contention_order%0d", k), 32'(acceptIds[k]), 32'(k % 2));
      end
    end
    waitDrain("contention");

    $display("[TB] backpressure");
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_data1_i = 32'd5;        req0_data2_i = 32'd7;        req0_ALUCtrl_i = 3'b010;
    req1_valid_i = 1'b1; req1_data1_i = 32'h000000F0; req1_data2_i = 32'h0000000F; req1_ALUCtrl_i = 3'b001;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req0_ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_accept0", 32'(seen), 32'd1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_rsp_seen", 32'(seen), 32'd1);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk_i);
      checkOutput($sformatf("bp_hold%0d_valid", j), 32'(rsp_valid_o), 32'd1);
      checkOutput($sformatf("bp_hold%0d_data", j), rsp_data_o, 32'd12);
      checkOutput($sformatf("bp_hold%0d_zero", j), 32'(rsp_Zero_o), 32'd0);
      checkOutput($sformatf("bp_hold%0d_id", j), 32'(rsp_id_o), 32'd0);
      checkOutput($sformatf("bp_hold%0d_ready0", j), 32'(req0_ready_o), 32'd0);
      checkOutput($sformatf("bp_hold%0d_ready1", j), 32'(req1_ready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("bp_idle_busy", 32'(busy_o), 32'd0);
    checkOutput("bp_idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("bp_idle_ready1", 32'(req1_ready_o), 32'd1);
    @(posedge clk_i); #1;
    checkOutput("bp_pending_accepted", 32'(busy_o), 32'd1);
    req1_valid_i = 1'b0;
    waitDrain("backpressure");

    checkOutput("sb_empty_at_end", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one ALU instance between two requesters: requester 0 (pipeline EX stage) and requester 1 (auxiliary address/loop unit).
- Arbitrates round-robin, captures operands and sequences the operation:
  - single-cycle for add/sub/and/or;
  - MUL_LAT cycles for multiply.
- Returns a registered result with valid/ready backpressure.
- Sits between the requesters and the shared ALU; owns the ALU control code and the zero flag.

Parameters:
- MUL_LAT, 3, cycles spent in multiply wait state; legal range 1..16.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_data1_i  in  32  operand A
- req0_data2_i  in  32  operand B
- req0_ALUCtrl_i  in  3  op code: 000 and, 001 or, 010 add, 110 sub, any other code = multiply
- req1_valid_i / req1_ready_o / req1_data1_i / req1_data2_i / req1_ALUCtrl_i  same as requester 0
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer takes result
- rsp_data_o  out  32  result
- rsp_Zero_o  out  1  1 when rsp_data_o == 0
- rsp_id_o  out  1  requester that issued the result
- busy_o  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, MULW, RESP.
- Reset (rst_i low, async):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie;
  - rsp_valid_o=0, rsp_data_o=0, rsp_Zero_o=0, rsp_id_o=0, busy_o=0;
  - operand regs=0, counter=0.
  - reqX_ready_o forced 0 while rst_i low.
  - Reset mid-operation discards the operation; no response is produced after release.
- reqX_ready_o is combinational: (state==IDLE) && grant==X && rst_i.
- Grant in IDLE:
  - only one valid -> that requester;
  - both valid -> the requester != last_grant.
- Accept = valid&ready. On accept:
  - latch data1, data2, ALUCtrl and id;
  - last_grant<=id.
- Next state after accept:
  - op in {000,001,010,110}, or MUL_LAT==1 -> EXEC;
  - otherwise -> MULW with counter<=MUL_LAT-1.
- No accept in EXEC, MULW or RESP; both ready outputs are 0 in these states.
- EXEC: one cycle; ALU output and zero flag registered into rsp_*; rsp_valid_o<=1; -> RESP.
- MULW:
  - counter decrements each cycle;
  - when counter==0, capture ALU output into rsp_*, rsp_valid_o<=1, -> RESP;
  - operand regs held stable throughout so the multiplier path sees constant inputs.
- Latency, with accept at the edge ending cycle T:
  - add/sub/and/or: rsp_valid_o high from cycle T+2;
  - multiply: rsp_valid_o high from cycle T+1+MUL_LAT.
- RESP:
  - rsp_* held stable while rsp_ready_i==0;
  - on rsp_ready_i==1: rsp_valid_o<=0, -> IDLE. A new accept is possible in the next cycle.
  - Minimum throughput: one op per 3 cycles.
- Arithmetic:
  - all results are 32 bits, modulo 2^32;
  - sub wraps; mul returns the low 32 bits of the product;
  - rsp_Zero_o computed in this block from the result, for every op code.
- Simultaneous events:
  - requester drops valid in the same cycle it would be granted: no accept, grant re-evaluated next cycle;
  - last_grant changes only on accept.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUCTRL_AND=3'b000, ALUCTRL_OR=3'b001, ALUCTRL_ADD=3'b010, ALUCTRL_SUB=3'b110, ALUCTRL_MUL=3'b100;
  - FSM state encoding (2 bits);
  - MUL_LAT legal-range constants.
- Instantiate the team's existing ALU block on the latched operand registers.
- Natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant register and update-on-accept input.

Test Plan:
- Reset mid-op: MUL_LAT=4, rst_i low during MULW -> rsp_valid_o=0 immediately, busy_o=0; no response after release; next req0 granted first.
- Single add: req0 5+7 ctrl 010 accepted cycle T -> rsp_valid_o=1 at T+2, rsp_data_o=12, rsp_Zero_o=0, rsp_id_o=0.
- Sub/zero/wrap: req1 9-9 ctrl 110 -> data 0, Zero 1, id 1; then 0-1 -> 0xFFFFFFFF, Zero 0.
- Contention: both valid continuously, req0 1+1, req1 0xF0|0x0F ctrl 001, rsp_ready_i=1 -> accept order 0,1,0,1; results 2, 0xFF alternating.
- Multiply: MUL_LAT=4, req0 3*0xFFFFFFFE ctrl 100 accepted T -> rsp_valid_o at T+5, data 0xFFFFFFFA; ctrl 111 gives the same latency and result.
- Backpressure: rsp_ready_i low 3 cycles in RESP -> rsp_* stable, both ready outputs 0 with requests pending; return to IDLE one cycle after rsp_ready_i=1, pending request accepted next cycle.
